// File: rtl/local_coincidence_gen.sv
// Per-channel trigger windows, a registered popcount threshold, hold-off and a saturating event count (optional LC_MULTIPLICITY_OUT_EN).
// Latency: 2 clocks from the edge sampling a trigger rise to local_coinc. Backpressure: none; enable = 0 flushes the pipeline.
module local_coincidence_gen #(
  parameter int N_CHANNELS = 24,
  parameter int W_WIDTH    = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [W_WIDTH-1:0]    lc_window_width,
  input  logic [7:0]            n_lc_thr,
  input  logic                  retrig_mode,
  input  logic [W_WIDTH-1:0]    holdoff,
  input  logic                  cnt_clr,
  input  logic [N_CHANNELS-1:0] trig,
  output logic [N_CHANNELS-1:0] local_coinc,
  output logic [CNT_WIDTH-1:0]  lc_count
`ifdef LC_MULTIPLICITY_OUT_EN
  ,
  output logic [7:0]            lc_multiplicity
`endif
);

  logic [N_CHANNELS-1:0] trig_q;
  logic [N_CHANNELS-1:0] rise;
  logic [N_CHANNELS-1:0] mem;
  logic [N_CHANNELS-1:0] mem_q;
  logic [N_CHANNELS-1:0] mem_qq;
  logic [W_WIDTH-1:0]    win_cnt [N_CHANNELS];
  logic [7:0]            pop;
  logic [7:0]            level_q;
  logic [W_WIDTH-1:0]    ho_cnt;
  logic                  fire;
  logic                  fire_q;

  assign rise = trig & ~trig_q;

  always_comb begin
    mem = '0;
    pop = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      mem[i] = rise[i] | (win_cnt[i] != '0);
      pop    = pop + {7'd0, mem_q[i]};
    end
  end

  assign fire = enable && (n_lc_thr != 8'd0) && (level_q >= n_lc_thr) && (ho_cnt == '0);

  // Reset to ones so a trigger already high when reset lifts is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= '1;
    end else begin
      trig_q <= trig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CHANNELS; i++) win_cnt[i] <= '0;
    end else if (!enable) begin
      for (int i = 0; i < N_CHANNELS; i++) win_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (rise[i] && ((win_cnt[i] == '0) || retrig_mode)) begin
          win_cnt[i] <= lc_window_width;
        end else if (win_cnt[i] != '0) begin
          win_cnt[i] <= win_cnt[i] - W_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      mem_qq      <= '0;
      level_q     <= '0;
      local_coinc <= '0;
      ho_cnt      <= '0;
    end else if (!enable) begin
      mem_q       <= '0;
      mem_qq      <= '0;
      level_q     <= '0;
      local_coinc <= '0;
      ho_cnt      <= '0;
    end else begin
      mem_q       <= mem;
      mem_qq      <= mem_q;
      level_q     <= pop;
      local_coinc <= fire ? mem_qq : '0;
      if (fire) begin
        ho_cnt <= holdoff;
      end else if (ho_cnt != '0) begin
        ho_cnt <= ho_cnt - W_WIDTH'(1);
      end
    end
  end

  // One count per contiguous run of firing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_q   <= 1'b0;
      lc_count <= '0;
    end else begin
      fire_q <= fire;
      if (cnt_clr) begin
        lc_count <= '0;
      end else if (fire && !fire_q && (lc_count != '1)) begin
        lc_count <= lc_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef LC_MULTIPLICITY_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc_multiplicity <= '0;
    end else begin
      lc_multiplicity <= fire ? level_q : 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_local_coincidence_gen.sv
// Bench for local_coincidence_gen: interval-based reference model feeding a scoreboard queue, directed and random stimulus.
module tb_local_coincidence_gen;
  localparam int N     = 24;
  localparam int WW    = 16;
  localparam int CW    = 4;
  localparam int NEVER = -1000000;

  typedef struct {
    logic [N-1:0]  lc;
    logic [CW-1:0] cnt;
    logic [7:0]    mult;
    int            t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [WW-1:0] lc_window_width;
  logic [7:0]    n_lc_thr;
  logic          retrig_mode;
  logic [WW-1:0] holdoff;
  logic          cnt_clr;
  logic [N-1:0]  trig;
  logic [N-1:0]  local_coinc;
  logic [CW-1:0] lc_count;
`ifdef LC_MULTIPLICITY_OUT_EN
  logic [7:0]    lc_multiplicity;
`endif

  always #5 clk = ~clk;

  local_coincidence_gen #(.N_CHANNELS(N), .W_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .lc_window_width(lc_window_width),
    .n_lc_thr(n_lc_thr),
    .retrig_mode(retrig_mode),
    .holdoff(holdoff),
    .cnt_clr(cnt_clr),
    .trig(trig),
    .local_coinc(local_coinc),
    .lc_count(lc_count)
`ifdef LC_MULTIPLICITY_OUT_EN
    , .lc_multiplicity(lc_multiplicity)
`endif
  );

  // Settings applied together with the next trigger vector.
  logic          s_en, s_rt, s_clr, s_release;
  logic [WW-1:0] s_w, s_ho;
  logic [7:0]    s_thr;

  // Reference model: each channel's window is the edge interval (start, start+len].
  int           win_start [N];
  int           win_len   [N];
  logic [N-1:0] m_trig_prev, mem_hist0, mem_hist1;
  bit           en_hist0, en_hist1, fire_prev;
  int           last_fire, ho_len, m_count, m_t;
  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      win_start[i] = NEVER;
      win_len[i]   = 0;
    end
    m_trig_prev = '1;
    mem_hist0 = '0;
    mem_hist1 = '0;
    en_hist0  = 1'b0;
    en_hist1  = 1'b0;
    fire_prev = 1'b0;
    last_fire = NEVER;
    ho_len    = 0;
    m_count   = 0;
    m_t       = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] rise, mem;
    bit   in_win, fire;
    int   pop;
    exp_t e;
    rise = trig & ~m_trig_prev;
    mem  = '0;
    for (int i = 0; i < N; i++) begin
      in_win = (m_t > win_start[i]) && (m_t <= win_start[i] + win_len[i]);
      mem[i] = rise[i] | in_win;
      if (!enable) begin
        win_start[i] = NEVER;
        win_len[i]   = 0;
      end else if (rise[i] && (!in_win || retrig_mode)) begin
        win_start[i] = m_t;
        win_len[i]   = int'(lc_window_width);
      end
    end
    pop  = $countones(mem_hist1);
    fire = enable && en_hist0 && en_hist1 && (n_lc_thr != 8'd0) &&
           (pop >= int'(n_lc_thr)) && (m_t > last_fire + ho_len);
    if (!enable) begin
      last_fire = NEVER;
      ho_len    = 0;
    end else if (fire) begin
      last_fire = m_t;
      ho_len    = int'(holdoff);
    end
    if (cnt_clr) m_count = 0;
    else if (fire && !fire_prev && m_count < (1 << CW) - 1) m_count++;
    fire_prev = fire;
    e.lc   = fire ? mem_hist1 : '0;
    e.mult = fire ? 8'(pop) : 8'd0;
    e.cnt  = CW'(m_count);
    e.t    = m_t;
    q.push_back(e);
    mem_hist1   = mem_hist0;
    mem_hist0   = mem;
    en_hist1    = en_hist0;
    en_hist0    = enable;
    m_trig_prev = trig;
    m_t++;
  endtask

  task automatic step(input logic [N-1:0] tr);
    @(negedge clk);
    if (s_release) begin
      rst_n = 1'b1;
      model_init();
      s_release = 1'b0;
    end
    enable          = s_en;
    lc_window_width = s_w;
    n_lc_thr        = s_thr;
    retrig_mode     = s_rt;
    holdoff         = s_ho;
    cnt_clr         = s_clr;
    trig            = tr;
    s_clr           = 1'b0;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0);
  endtask

  // One-edge-wide pulses on up to three masks at given edge offsets.
  task automatic pulses(input int len, input logic [N-1:0] m0, input int e0,
                        input logic [N-1:0] m1, input int e1,
                        input logic [N-1:0] m2, input int e2);
    logic [N-1:0] tr;
    for (int e = 0; e < len; e++) begin
      tr = '0;
      if (e == e0) tr = tr | m0;
      if (e == e1) tr = tr | m1;
      if (e == e2) tr = tr | m2;
      step(tr);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (local_coinc !== '0 || lc_count !== '0) begin
      errors++;
      $display("FAIL %s: local_coinc=%h lc_count=%0d, required 0 and 0", name, local_coinc, lc_count);
    end
  endtask

  // Scoreboard monitor: one queued expectation per sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (local_coinc !== e.lc) begin
          errors++;
          $display("FAIL local_coinc edge %0d: got %h required %h", e.t, local_coinc, e.lc);
        end
        checks++;
        if (lc_count !== e.cnt) begin
          errors++;
          $display("FAIL lc_count edge %0d: got %0d required %0d", e.t, lc_count, e.cnt);
        end
`ifdef LC_MULTIPLICITY_OUT_EN
        checks++;
        if (lc_multiplicity !== e.mult) begin
          errors++;
          $display("FAIL lc_multiplicity edge %0d: got %0d required %0d", e.t, lc_multiplicity, e.mult);
        end
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] tr;
    rst_n = 1'b0;
    enable = 1'b1; lc_window_width = '0; n_lc_thr = 8'd0; retrig_mode = 1'b0;
    holdoff = '0; cnt_clr = 1'b0; trig = '0;
    s_en = 1'b1; s_w = 16'd10; s_thr = 8'd2; s_rt = 1'b0; s_ho = '0; s_clr = 1'b0;
    s_release = 1'b1;
    model_init();
    #22;
    check_zero("reset_state");

    // Basic overlap: ch0 at E0, ch5 at E7 / E10 / E11.
    idle(3);
    pulses(30, 24'h000001, 0, 24'h000020, 7, '0, -1);
    pulses(30, 24'h000001, 0, 24'h000020, 10, '0, -1);
    pulses(30, 24'h000001, 0, 24'h000020, 11, '0, -1);

    // Retrigger on/off.
    s_rt = 1'b1;
    pulses(35, 24'h000001, 0, 24'h000001, 5, 24'h000002, 14);
    s_rt = 1'b0;
    pulses(35, 24'h000001, 0, 24'h000001, 5, 24'h000002, 14);

    // Hold-off 20.
    s_ho = 16'd20;
    pulses(40, 24'h000003, 0, '0, -1, '0, -1);
    s_ho = '0;

    // Threshold extremes.
    s_thr = 8'd0;
    pulses(20, 24'hFFFFFF, 0, '0, -1, '0, -1);
    s_thr = 8'd24;
    pulses(20, 24'hFFFFFF, 0, '0, -1, '0, -1);
    s_thr = 8'd25;
    pulses(20, 24'hFFFFFF, 0, '0, -1, '0, -1);

    // Counter saturation then clear.
    s_thr = 8'd2; s_w = '0;
    for (int k = 0; k < 20; k++) pulses(4, 24'h000003, 0, '0, -1, '0, -1);
    s_clr = 1'b1;
    idle(3);

    // Enable drop mid-window.
    s_w = 16'd10;
    step(24'h00000C);
    idle(3);
    s_en = 1'b0;
    step(24'h000030);
    s_en = 1'b1;
    idle(20);

    // Randomised blocks with mid-window configuration changes.
    tr = '0;
    for (int blk = 0; blk < 20; blk++) begin
      s_w   = WW'($urandom_range(0, 12));
      s_thr = 8'($urandom_range(0, 8));
      s_rt  = 1'($urandom_range(0, 1));
      s_ho  = WW'($urandom_range(0, 6));
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 31) == 0) tr[i] = ~tr[i];
        s_en  = ($urandom_range(0, 39) != 0);
        s_clr = ($urandom_range(0, 59) == 0);
        step(tr);
      end
    end
    s_en = 1'b1;
    idle(20);

    // Async reset mid-window with triggers held high.
    s_w = 16'd10; s_thr = 8'd2; s_ho = '0; s_rt = 1'b0;
    idle(3);
    for (int k = 0; k < 5; k++) step('1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_window");
    repeat (3) @(posedge clk);
    s_release = 1'b1;
    for (int k = 0; k < 20; k++) step('1);
    idle(5);

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/local_coincidence_gen.md
Name: local_coincidence_gen

Overview:
Parametrised successor to the trigger-level local coincidence former. Per-channel window counters open a coincidence window on each trigger rising edge. A registered population count compares the number of open windows against a threshold. Compared with the earlier block, it adds retrigger mode, a dead-time hold-off after each coincidence, an enable, and a saturating event counter. It sits between the per-channel discriminator triggers and the readout trigger logic.

Parameters:
N_CHANNELS, 24, number of trigger inputs (1..255)
W_WIDTH, 16, width of window and hold-off counters
CNT_WIDTH, 32, width of coincidence event counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = block active; 0 = synchronously flush all state
lc_window_width  in  W_WIDTH  extra window length in clocks beyond the edge cycle
n_lc_thr  in  8  required number of channels in coincidence; 0 = never fire
retrig_mode  in  1  1 = a rising edge inside an open window reloads it
holdoff  in  W_WIDTH  dead-time clocks after each firing cycle
cnt_clr  in  1  synchronous clear of lc_count
trig  in  N_CHANNELS  trigger components, level signals
local_coinc  out  N_CHANNELS  member mask of the active coincidence, else 0
lc_count  out  CNT_WIDTH  coincidence event count, saturating

Behaviour:
- Reset: trig_q = all ones, so a trigger held high through reset produces no edge.
- Reset: window counters, holdoff counter, pipeline registers, local_coinc and lc_count = 0.
- Edge detect: rise[i] = trig[i] & ~trig_q[i]. trig_q <= trig every cycle, including when enable = 0.
- Window counter cnt[i]:
  - rise with (cnt = 0 or retrig_mode) -> load lc_window_width.
  - rise with cnt != 0 and retrig_mode = 0 -> ignored, counter keeps decrementing.
  - no rise and cnt != 0 -> decrement.
  - Rise and expiry in the same cycle -> load wins.
- Membership: mem[i] = rise[i] | (cnt[i] != 0). A channel is therefore a member for lc_window_width+1 consecutive sampling edges, starting at the edge that samples the rise.
- Pipeline (latency 2 clocks from the sampling edge):
  - Edge k: mem_q <= mem.
  - Edge k+1: level_q <= popcount(mem_q), an 8-bit result; mem_qq <= mem_q.
  - Edge k+2: fire = enable & (n_lc_thr != 0) & (level_q >= n_lc_thr) & (ho_cnt = 0). local_coinc <= fire ? mem_qq : 0.
- Hold-off:
  - A firing cycle loads ho_cnt with holdoff. Otherwise ho_cnt decrements while nonzero.
  - holdoff = 0 -> no dead time; output may stay asserted on consecutive cycles.
- lc_count:
  - Increments on each cycle where fire = 1 and the previous cycle's fire = 0.
  - Saturates at all ones.
  - cnt_clr has priority over increment.
- enable = 0: window counters, mem_q, level_q, mem_qq, ho_cnt and local_coinc are cleared on the next edge. lc_count holds.
- Changing lc_window_width or holdoff mid-window affects only subsequent loads.
- Asynchronous reset mid-window clears everything immediately; no output until a new rising edge occurs.

Optional Feature:
LC_MULTIPLICITY_OUT_EN:
- Defined: adds output port lc_multiplicity [7:0], reset 0, registered. It equals level_q on firing cycles, aligned with local_coinc, and 0 otherwise.
- Undefined: port and register absent; all other behaviour unchanged.

Test Plan:
- Default parameters, W=10, thr=2, holdoff=0, retrig=0. ch0 rises at E0, ch5 at E7 -> local_coinc = 0x000021 at edges E9..E12, 0 from E13; lc_count = 1.
- Same settings, ch5 rises at E10 -> 0x000021 for exactly one cycle at E12. ch5 at E11 instead -> never asserted.
- W=10, thr=2. ch0 rises at E0 and E5 (falls in between), ch1 rises at E14:
  - retrig=1 -> 0x000003 at E16.
  - retrig=0 -> no output.
- W=10, thr=2, holdoff=20. ch0 and ch1 rise together at E0 -> 0x000003 at E2 only; 0 through E22; lc_count = 1.
- thr=0 with all channels pulsed -> no output. thr=24 with all channels pulsed at E0 -> 0xFFFFFF at E2.
- CNT_WIDTH=4, holdoff=0: 20 separated coincidences -> lc_count saturates at 15; cnt_clr -> 0.
- rst_n low at E5 mid-window with trig held high -> outputs 0 immediately. After release with trig still high -> no output.
